// File: rtl/cu_pkg.sv
// Shared types and instruction-field constants for the control unit and its PC.
// Optional jump support is selected in control_unit by the CU_JUMP_EN macro.
package cu_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_HALT  = 4'b0011;
    localparam logic [3:0] OP_JUMP  = 4'b0100;

    // Bit positions within the 16-bit instruction word.
    localparam int F_OP_LSB    = 12;
    localparam int F_DADDR_LSB = 4;
    localparam int F_MREG_LSB  = 0;
    localparam int F_W_LSB     = 8;
    localparam int F_A_LSB     = 4;
    localparam int F_B_LSB     = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_rsvd_class(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: increments (wrapping) or loads a jump target; load wins over increment.
// Asynchronously cleared to 0 by rst_n.
module pc_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_pc
);

    logic [W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the datapath control inputs until HALT.
// Build with CU_JUMP_EN defined to make opcode 0100 a PC-load jump instead of reserved.
import cu_pkg::*;

module control_unit #(
    parameter int INSTR_W  = 16,
    parameter int I_ADDR_W = 7,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  I_data,
    output logic [I_ADDR_W-1:0] I_addr,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic                D_wr,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic                RF_W_en,
    output logic                RF_s,
    output logic [3:0]          ALU_sel,
    output logic                halted,
    output logic                illegal
);

    state_t                r_state;
    state_t                w_next;
    logic [INSTR_W-1:0]    r_ir;
    logic                  r_illegal;
    logic [I_ADDR_W-1:0]   w_pc;
    logic                  w_pc_inc;
    logic                  w_pc_load;
    logic                  w_is_jump;
    logic                  w_is_rsvd;
    logic [3:0]            w_op;
    logic [D_ADDR_W-1:0]   w_daddr;
    logic [R_ADDR_W-1:0]   w_mreg;
    logic [R_ADDR_W-1:0]   w_wreg;
    logic [R_ADDR_W-1:0]   w_areg;
    logic [R_ADDR_W-1:0]   w_breg;

    assign w_op    = r_ir[F_OP_LSB +: 4];
    assign w_daddr = r_ir[F_DADDR_LSB +: D_ADDR_W];
    assign w_mreg  = r_ir[F_MREG_LSB +: R_ADDR_W];
    assign w_wreg  = r_ir[F_W_LSB +: R_ADDR_W];
    assign w_areg  = r_ir[F_A_LSB +: R_ADDR_W];
    assign w_breg  = r_ir[F_B_LSB +: R_ADDR_W];

`ifdef CU_JUMP_EN
    assign w_is_jump = (w_op == OP_JUMP);
`else
    assign w_is_jump = 1'b0;
`endif

    // Anything in the 01xx class that is not an enabled jump behaves as NOOP and flags illegal.
    assign w_is_rsvd = is_rsvd_class(w_op) && !w_is_jump;

    assign w_pc_inc  = (r_state == S_FETCH);
    assign w_pc_load = (r_state == S_EXEC) && w_is_jump;

    pc_counter #(
        .W(I_ADDR_W)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_pc_inc),
        .i_load     (w_pc_load),
        .i_load_val (r_ir[I_ADDR_W-1:0]),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_ir <= I_data;
            end
            if ((r_state == S_EXEC) && w_is_rsvd) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        D_addr    = '0;
        D_wr      = 1'b0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        RF_W_en   = 1'b0;
        RF_s      = 1'b0;
        ALU_sel   = 4'h0;
        halted    = 1'b0;

        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_FETCH;
                if (is_alu_op(w_op)) begin
                    ALU_sel   = {1'b0, w_op[2:0]};
                    RF_W_addr = w_wreg;
                    RF_A_addr = w_areg;
                    RF_B_addr = w_breg;
                    RF_W_en   = 1'b1;
                end else begin
                    case (w_op)
                        OP_LOAD: begin
                            // Memory read data arrives next cycle; the write happens in EXEC2.
                            D_addr    = w_daddr;
                            RF_W_addr = w_mreg;
                            w_next    = S_EXEC2;
                        end
                        OP_STORE: begin
                            D_addr    = w_daddr;
                            RF_A_addr = w_mreg;
                            D_wr      = 1'b1;
                        end
                        OP_HALT: w_next = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_EXEC2: begin
                D_addr    = w_daddr;
                RF_W_addr = w_mreg;
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end
            default: w_next = S_INIT;
        endcase
    end

    assign I_addr  = w_pc;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, LOAD/STORE/ALU/HALT sequencing, reserved/jump op, PC wrap, async reset.
// Instruction ROM is modelled with a one-cycle registered read.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] I_data;
    logic [6:0]  I_addr;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_A_addr;
    logic [3:0]  RF_B_addr;
    logic        RF_W_en;
    logic        RF_s;
    logic [3:0]  ALU_sel;
    logic        halted;
    logic        illegal;

    logic [15:0] rom [128];
    int          n_tests;
    int          n_fail;

    control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I_data    (I_data),
        .I_addr    (I_addr),
        .D_addr    (D_addr),
        .D_wr      (D_wr),
        .RF_W_addr (RF_W_addr),
        .RF_A_addr (RF_A_addr),
        .RF_B_addr (RF_B_addr),
        .RF_W_en   (RF_W_en),
        .RF_s      (RF_s),
        .ALU_sel   (ALU_sel),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) I_data <= rom[I_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // {D_addr, D_wr, RF_W_addr, RF_A_addr, RF_B_addr, RF_W_en, RF_s, ALU_sel, halted}
    function automatic logic [31:0] ctl();
        return {5'd0, D_addr, D_wr, RF_W_addr, RF_A_addr, RF_B_addr, RF_W_en, RF_s, ALU_sel, halted};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Holds reset two cycles, releases it, and leaves the DUT in INIT.
    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clear_rom();
        rom[0] = 16'h1053;
        rom[1] = 16'h2A71;
        rom[2] = 16'hA312;
        rom[3] = 16'h3000;

        // Reset and INIT
        step(2);
        check("rst_ctl", ctl(), 32'h0);
        check("rst_iaddr", {25'd0, I_addr}, 32'h0);
        check("rst_illegal", {31'd0, illegal}, 32'h0);
        rst_n = 1'b1;
        check("init_ctl", ctl(), 32'h0);
        step(1);
        check("fetch0_iaddr", {25'd0, I_addr}, 32'h0);
        check("fetch0_ctl", ctl(), 32'h0);

        // LOAD 1053
        step(1);
        check("decode_ctl", ctl(), 32'h0);
        step(1);
        check("load_exec_daddr", {24'd0, D_addr}, 32'h05);
        check("load_exec_wen", {31'd0, RF_W_en}, 32'h0);
        check("load_exec_dwr", {31'd0, D_wr}, 32'h0);
        step(1);
        check("load_exec2_waddr", {28'd0, RF_W_addr}, 32'h3);
        check("load_exec2_rfs", {31'd0, RF_s}, 32'h1);
        check("load_exec2_wen", {31'd0, RF_W_en}, 32'h1);
        check("load_exec2_daddr", {24'd0, D_addr}, 32'h05);
        step(1);
        check("fetch1_iaddr", {25'd0, I_addr}, 32'h1);
        check("fetch1_ctl", ctl(), 32'h0);

        // STORE 2A71
        step(2);
        check("store_daddr", {24'd0, D_addr}, 32'hA7);
        check("store_aaddr", {28'd0, RF_A_addr}, 32'h1);
        check("store_dwr", {31'd0, D_wr}, 32'h1);
        check("store_wen", {31'd0, RF_W_en}, 32'h0);
        step(1);
        check("fetch2_iaddr", {25'd0, I_addr}, 32'h2);
        check("fetch2_dwr", {31'd0, D_wr}, 32'h0);

        // ALU A312
        step(2);
        check("alu_sel", {28'd0, ALU_sel}, 32'h2);
        check("alu_regs", {20'd0, RF_W_addr, RF_A_addr, RF_B_addr}, 32'h312);
        check("alu_wen_rfs", {30'd0, RF_W_en, RF_s}, 32'h2);
        check("alu_dwr", {31'd0, D_wr}, 32'h0);
        step(1);
        check("fetch3_iaddr", {25'd0, I_addr}, 32'h3);

        // HALT 3000
        step(2);
        check("halt_exec_ctl", ctl(), 32'h0);
        step(1);
        check("halted", ctl(), 32'h1);
        step(10);
        check("halted_stays", ctl(), 32'h1);
        check("halted_iaddr", {25'd0, I_addr}, 32'h4);
        check("halted_illegal", {31'd0, illegal}, 32'h0);

        // Opcode 0100
        clear_rom();
        rom[0] = 16'h4005;
        do_reset();
        check("rst2_halted", {31'd0, halted}, 32'h0);
        step(3);
        check("op4_exec_ctl", ctl(), 32'h0);
        step(1);
`ifdef CU_JUMP_EN
        check("op4_iaddr", {25'd0, I_addr}, 32'h5);
        check("op4_illegal", {31'd0, illegal}, 32'h0);
`else
        check("op4_iaddr", {25'd0, I_addr}, 32'h1);
        check("op4_illegal", {31'd0, illegal}, 32'h1);
`endif

        // Reserved 0101 is always illegal and sticky until reset
        clear_rom();
        rom[0] = 16'h5000;
        do_reset();
        check("rst3_illegal", {31'd0, illegal}, 32'h0);
        step(4);
        check("op5_illegal", {31'd0, illegal}, 32'h1);
        step(9);
        check("op5_illegal_sticky", {31'd0, illegal}, 32'h1);
        check("op5_iaddr", {25'd0, I_addr}, 32'h4);

        // PC wrap 127 -> 0 over a ROM of NOOPs
        clear_rom();
        do_reset();
        step(1 + 3 * 127);
        check("wrap_fetch127", {25'd0, I_addr}, 32'd127);
        step(3);
        check("wrap_fetch0", {25'd0, I_addr}, 32'd0);

        // Asynchronous reset in the middle of an ALU EXEC
        rom[0] = 16'hA312;
        do_reset();
        step(3);
        check("mid_alu_wen", {31'd0, RF_W_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", ctl(), 32'h0);
        check("async_rst_pc", {25'd0, I_addr}, 32'h0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("after_rst_fetch", {25'd0, I_addr}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
